// File: rtl/serial_subtractor_if.sv
// Request/result bundle for the bit-serial subtractor.
// Master side (sequencer) drives start and operands; slave side (subtractor)
// returns ready/busy handshake plus the registered result and a valid strobe.
interface serial_subtractor_if #(
  parameter int N = 3
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         borrow_in;
  logic         ready;
  logic         busy;
  logic         valid;
  logic [N-1:0] diff;
  logic         borrow_out;

  modport master (
    output start, a, b, borrow_in,
    input  ready, busy, valid, diff, borrow_out
  );

  modport slave (
    input  start, a, b, borrow_in,
    output ready, busy, valid, diff, borrow_out
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor a - b - borrow_in, LSB first, one cell per clock.
// Latency: accept edge k, bits on edges k+1..k+N, valid in the cycle after k+N.
// Backpressure: ready low for the N RUN cycles; start/operands ignored then.
// Ports: clk, rst_n (async active-low), bus (slave modport: start/a/b/borrow_in
//        in; ready/busy/valid/diff/borrow_out out).
module serial_subtractor #(
  parameter int N = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int             CW   = $clog2(N + 1);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  state_t         state_q, state_d;
  logic [N-1:0]   ra_q, ra_d;
  logic [N-1:0]   rb_q, rb_d;
  logic [N-1:0]   res_q, res_d;
  logic [N-1:0]   diff_q, diff_d;
  logic           bw_q, bw_d;
  logic           bout_q, bout_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           accept;
  logic           cell_d;
  logic           cell_bw;
  logic           last_bit;

  // Full-subtractor cell on the current LSBs and the running borrow.
  assign cell_d   = ra_q[0] ^ rb_q[0] ^ bw_q;
  assign cell_bw  = (~ra_q[0] & rb_q[0]) | (~(ra_q[0] ^ rb_q[0]) & bw_q);
  assign last_bit = (cnt_q == LAST);

  // DONE also accepts, which is what makes back-to-back issue possible.
  assign accept   = bus.start && (state_q != RUN);

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    res_d   = res_q;
    diff_d  = diff_q;
    bw_d    = bw_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          ra_d    = bus.a;
          rb_d    = bus.b;
          bw_d    = bus.borrow_in;
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        ra_d         = ra_q >> 1;
        rb_d         = rb_q >> 1;
        res_d        = res_q >> 1;
        res_d[N-1]   = cell_d;
        bw_d         = cell_bw;
        if (last_bit) begin
          // Publish only once the final bit is in; diff holds until the
          // next completed operation.
          diff_d  = res_d;
          bout_d  = cell_bw;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      bw_q    <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      bw_q    <= bw_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ready      = (state_q != RUN);
  assign bus.busy       = (state_q == RUN);
  assign bus.valid      = (state_q == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = bout_q;

endmodule
